// File: rtl/textbuf_if.sv
// Requester (ports A and B) and bulk-operation handshake bundle for textbuf_ctl.
interface textbuf_if #(
    parameter int LOG2TXT = 8
);
    logic               a_req, a_we, a_ack;
    logic [LOG2TXT-1:0] a_addr;
    logic [7:0]         a_data, a_q;
    logic               b_req, b_we, b_ack;
    logic [LOG2TXT-1:0] b_addr;
    logic [7:0]         b_data, b_q;
    logic               clr_req, scroll_req, busy, op_done;

    modport master (
        output a_req, a_we, a_addr, a_data,
        output b_req, b_we, b_addr, b_data,
        output clr_req, scroll_req,
        input  a_ack, a_q, b_ack, b_q, busy, op_done
    );

    modport slave (
        input  a_req, a_we, a_addr, a_data,
        input  b_req, b_we, b_addr, b_data,
        input  clr_req, scroll_req,
        output a_ack, a_q, b_ack, b_q, busy, op_done
    );
endinterface

// File: rtl/textbuf_ctl.sv
// Port-B sequencer of the OSD text buffer: two-requester arbitration plus clear/scroll-up.
// Scroll-up is built only when TEXTBUF_SCROLL_EN is defined.
module textbuf_ctl #(
    parameter int         WINDOW_W = 32,
    parameter int         WINDOW_H = 8,
    parameter int         LOG2TXT  = 8,
    parameter logic [7:0] FILL     = 8'h20
) (
    input  logic               clk,
    input  logic               reset_n,
    textbuf_if.slave           bus,
    output logic [LOG2TXT-1:0] mem_addr,
    output logic [7:0]         mem_data,
    output logic               mem_wren,
    input  logic [7:0]         mem_q
);
    localparam int CW = LOG2TXT + 1;
    localparam logic [CW-1:0] LAST_CELL = CW'(2**LOG2TXT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        CLEAR,
`ifdef TEXTBUF_SCROLL_EN
        SCR_RD,
        SCR_WR,
        SCR_FILL,
`endif
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_b, last_b_nxt;
    logic          pclr, pscr;
    logic          clr_start, sel_b;

    // Round-robin: B wins only if A is idle or A was served last.
    assign sel_b    = bus.b_req && (!bus.a_req || !last_b);
    assign bus.busy = pclr | pscr | ((state != IDLE) && (state != ACC));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
            pclr   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last_b <= last_b_nxt;
            if (bus.clr_req)
                pclr <= 1'b1;
            else if (clr_start)
                pclr <= 1'b0;
        end
    end

`ifdef TEXTBUF_SCROLL_EN
    localparam logic [CW-1:0] ROW_W    = CW'(WINDOW_W);
    localparam logic [CW-1:0] SCR_LAST = CW'(WINDOW_W * (WINDOW_H - 1) - 1);
    logic          scr_start;
    logic [CW-1:0] rd_idx;

    assign rd_idx = cnt + ROW_W;

    // A simultaneous clear pulse suppresses the scroll; a starting clear cancels it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pscr <= 1'b0;
        else if (bus.scroll_req && !bus.clr_req)
            pscr <= 1'b1;
        else if (scr_start || clr_start)
            pscr <= 1'b0;
    end
`else
    logic unused_scroll;
    assign unused_scroll = bus.scroll_req;
    assign pscr          = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_b_nxt  = last_b;
        clr_start   = 1'b0;
`ifdef TEXTBUF_SCROLL_EN
        scr_start   = 1'b0;
`endif
        mem_addr    = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        bus.a_ack   = 1'b0;
        bus.a_q     = '0;
        bus.b_ack   = 1'b0;
        bus.b_q     = '0;
        bus.op_done = 1'b0;
        case (state)
            IDLE: begin
                if (pclr) begin
                    clr_start = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = CLEAR;
`ifdef TEXTBUF_SCROLL_EN
                end else if (pscr) begin
                    scr_start = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SCR_RD;
`endif
                end else if (bus.a_req || bus.b_req) begin
                    mem_addr   = sel_b ? bus.b_addr : bus.a_addr;
                    mem_data   = sel_b ? bus.b_data : bus.a_data;
                    mem_wren   = sel_b ? bus.b_we   : bus.a_we;
                    last_b_nxt = sel_b;
                    state_nxt  = ACC;
                end
            end
            // last_b now names the requester granted in the previous cycle.
            ACC: begin
                if (last_b) begin
                    bus.b_ack = 1'b1;
                    bus.b_q   = mem_q;
                end else begin
                    bus.a_ack = 1'b1;
                    bus.a_q   = mem_q;
                end
                state_nxt = IDLE;
            end
            CLEAR: begin
                mem_addr = cnt[LOG2TXT-1:0];
                mem_data = FILL;
                mem_wren = 1'b1;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == LAST_CELL)
                    state_nxt = DONE;
            end
`ifdef TEXTBUF_SCROLL_EN
            SCR_RD: begin
                mem_addr  = rd_idx[LOG2TXT-1:0];
                state_nxt = SCR_WR;
            end
            SCR_WR: begin
                mem_addr  = cnt[LOG2TXT-1:0];
                mem_data  = mem_q;
                mem_wren  = 1'b1;
                cnt_nxt   = cnt + CW'(1);
                state_nxt = (cnt == SCR_LAST) ? SCR_FILL : SCR_RD;
            end
            SCR_FILL: begin
                mem_addr = cnt[LOG2TXT-1:0];
                mem_data = FILL;
                mem_wren = 1'b1;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == LAST_CELL)
                    state_nxt = DONE;
            end
`endif
            DONE: begin
                bus.op_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_textbuf_ctl.sv
// Bench for textbuf_ctl: directed steps plus random single accesses, checked against a
// behavioural model of the text buffer (array of cells, round-robin fairness rule).
module tb_textbuf_ctl;
    localparam int         W       = 32;
    localparam int         H       = 8;
    localparam int         LOG2TXT = 8;
    localparam int         CELLS   = 256;
    localparam logic [7:0] FILL    = 8'h20;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [LOG2TXT-1:0] mem_addr;
    logic [7:0]         mem_data;
    logic               mem_wren;
    logic [7:0]         mem_q;

    textbuf_if #(.LOG2TXT(LOG2TXT)) bus ();

    textbuf_ctl #(.WINDOW_W(W), .WINDOW_H(H), .LOG2TXT(LOG2TXT), .FILL(FILL)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .mem_q    (mem_q)
    );

    always #5 clk = ~clk;

    // Screen buffer port B: synchronous write, registered read.
    logic [7:0] buf_mem [CELLS];
    always @(posedge clk) begin
        if (mem_wren)
            buf_mem[mem_addr] <= mem_data;
        mem_q <= buf_mem[mem_addr];
    end

    logic [7:0] ref_mem [CELLS];
    logic       last_b = 1'b1;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] g_addr, g_data;
    logic       g_wren;
    int         cross_bad = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_ack"}, bus.a_ack, 0);
        check({tag, "_b_ack"}, bus.b_ack, 0);
        check({tag, "_a_q"}, bus.a_q, 0);
        check({tag, "_b_q"}, bus.b_q, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_mem_wren"}, mem_wren, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_op_done"}, bus.op_done, 0);
    endtask

    task automatic compare_buf(input string tag);
        int bad = 0;
        for (int i = 0; i < CELLS; i++)
            if (buf_mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // One single-cell access from an idle requester; lat = cycles from grant to ack.
    task automatic do_access(input bit port, input bit we, input logic [7:0] addr,
                             input logic [7:0] data, output logic [7:0] q, output int lat);
        tick();
        if (!port) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_data = data;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_data = data;
        end
        #1;
        g_addr = mem_addr; g_data = mem_data; g_wren = mem_wren;
        lat = -1;
        q = 8'h00;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if ((!port && bus.a_ack) || (port && bus.b_ack)) begin
                q   = port ? bus.b_q : bus.a_q;
                lat = n;
                if ((port ? bus.a_ack : bus.b_ack) || (port ? bus.a_q : bus.b_q) != 8'h00)
                    cross_bad++;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        if (lat > 0) begin
            last_b = port;
            if (we) ref_mem[addr] = data;
        end
    endtask

    initial begin
        logic [7:0] q, addr, d, expd;
        int lat, nacks, both, nwr, bad, done_at, ack_at, ndone, lat_bad, hit;
        bit p, we, exp_b;

        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.clr_req = 0; bus.scroll_req = 0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        tick();
        check("reset_busy", bus.busy, 0);

        // Both requesters held high: fairness model alternates starting with A.
        bus.a_we = 1; bus.a_addr = 8'h10; bus.a_data = 8'hA1;
        bus.b_we = 1; bus.b_addr = 8'h11; bus.b_data = 8'hB2;
        bus.a_req = 1; bus.b_req = 1;
        nacks = 0; both = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.a_ack && bus.b_ack) both++;
            if (bus.a_ack || bus.b_ack) begin
                exp_b = !last_b;
                check($sformatf("rr_grant%0d_is_b", nacks), bus.b_ack, exp_b);
                last_b = bus.b_ack;
                nacks++;
            end
        end
        bus.a_req = 0; bus.b_req = 0;
        check("rr_ack_count", nacks, 4);
        check("rr_both_acks", both, 0);
        ref_mem[8'h10] = 8'hA1;
        ref_mem[8'h11] = 8'hB2;

        do_access(0, 1, 8'h05, 8'h41, q, lat);
        check("a_wr_lat", lat, 1);
        check("a_wr_grant_addr", g_addr, 8'h05);
        check("a_wr_grant_data", g_data, 8'h41);
        check("a_wr_grant_wren", g_wren, 1);
        do_access(0, 0, 8'h05, 8'h00, q, lat);
        check("a_rd_lat", lat, 1);
        check("a_rd_grant_wren", g_wren, 0);
        check("a_rd_q", q, 8'h41);

        // Clear: busy the cycle after the pulse, 256 ascending fill writes, done on the 257th.
        tick(); bus.clr_req = 1;
        tick(); bus.clr_req = 0;
        check("clr_busy", bus.busy, 1);
        check("clr_pending_nowrite", mem_wren, 0);
        nwr = 0; bad = 0; done_at = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (mem_wren) begin
                if (mem_addr !== nwr[7:0] || mem_data !== FILL) bad++;
                nwr++;
            end
            if (bus.op_done) begin done_at = n; break; end
        end
        check("clr_writes", nwr, 256);
        check("clr_order_data", bad, 0);
        check("clr_done_cycle", done_at, 257);
        tick();
        check("clr_busy_after", bus.busy, 0);
        check("clr_done_pulse", bus.op_done, 0);
        for (int i = 0; i < CELLS; i++) ref_mem[i] = FILL;
        compare_buf("clr_buf");

        // Random single accesses against the cell model.
        lat_bad = 0;
        for (int k = 0; k < 120; k++) begin
            p    = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 255));
            d    = 8'($urandom_range(0, 255));
            expd = ref_mem[addr];
            do_access(p, we, addr, d, q, lat);
            if (!we) check($sformatf("rnd_rd_%0h", addr), q, expd);
            if (lat != 1) lat_bad++;
        end
        check("rnd_latency", lat_bad, 0);
        check("rnd_other_port_quiet", cross_bad, 0);
        compare_buf("rnd_buf");

`ifdef TEXTBUF_SCROLL_EN
        for (int c = 0; c < CELLS; c++)
            do_access(1, 1, c[7:0], 8'(c / W), q, lat);
        compare_buf("rows_buf");
        tick(); bus.scroll_req = 1;
        tick(); bus.scroll_req = 0;
        check("scr_busy", bus.busy, 1);
        done_at = -1;
        for (int n = 1; n <= 700; n++) begin
            tick();
            if (bus.op_done) begin done_at = n; break; end
        end
        check("scr_done_cycle", done_at, 2 * W * (H - 1) + W + 1);
        tick();
        check("scr_busy_after", bus.busy, 0);
        for (int i = 0; i < CELLS - W; i++) ref_mem[i] = ref_mem[i + W];
        for (int i = CELLS - W; i < CELLS; i++) ref_mem[i] = FILL;
        compare_buf("scr_buf");
`else
        tick(); bus.scroll_req = 1;
        tick(); bus.scroll_req = 0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.busy || mem_wren || bus.op_done) bad++;
            tick();
        end
        check("scr_ignored", bad, 0);
        compare_buf("scr_ignored_buf");
`endif

        // Clear and scroll together: one clear only; B raised mid-clear waits for op_done.
        tick(); bus.clr_req = 1; bus.scroll_req = 1;
        tick(); bus.clr_req = 0; bus.scroll_req = 0;
        ndone = 0; done_at = -1; ack_at = -1;
        for (int n = 1; n <= 800; n++) begin
            if (n == 20) begin
                bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h33; bus.b_data = 8'h5A;
            end
            tick();
            if (bus.op_done) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (bus.b_ack) begin
                if (ack_at < 0) ack_at = n;
                bus.b_req = 0;
            end
        end
        check("both_ndone", ndone, 1);
        check("both_done_cycle", done_at, 257);
        check("both_b_ack_cycle", ack_at, 259);
        check("both_busy_after", bus.busy, 0);
        last_b = 1'b1;
        for (int i = 0; i < CELLS; i++) ref_mem[i] = FILL;
        ref_mem[8'h33] = 8'h5A;
        compare_buf("both_buf");

        // Reset asserted in the middle of a clear.
        tick(); bus.clr_req = 1;
        tick(); bus.clr_req = 0;
        hit = 0;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (mem_wren && mem_addr == 8'd100) begin hit = 1; break; end
        end
        check("rst_reached_100", hit, 1);
        reset_n = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        check("rst_hold_wren", mem_wren, 0);
        reset_n = 1'b1;
        tick();
        check("rst_after_busy", bus.busy, 0);
        do_access(0, 0, 8'h00, 8'h00, q, lat);
        check("rst_after_access_lat", lat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
